// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: glyph decode, anode scan with blanking,
// per-digit blink and double-buffered glyph/dp updates committed at frame wrap.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST   = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]  BLANK_L     = SLOT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]   DIG_LAST    = DIG_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [4:0]         GLYPH_BLANK = 5'h16;

  function automatic logic [6:0] decode_glyph(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'h00:   seg = 7'h01;
      5'h01:   seg = 7'h4F;
      5'h02:   seg = 7'h12;
      5'h03:   seg = 7'h06;
      5'h04:   seg = 7'h4C;
      5'h05:   seg = 7'h24;
      5'h06:   seg = 7'h20;
      5'h07:   seg = 7'h0F;
      5'h08:   seg = 7'h00;
      5'h09:   seg = 7'h04;
      5'h0A:   seg = 7'h08;
      5'h0B:   seg = 7'h60;
      5'h0C:   seg = 7'h31;
      5'h0D:   seg = 7'h42;
      5'h0E:   seg = 7'h30;
      5'h0F:   seg = 7'h38;
      5'h10:   seg = 7'h70;
      5'h11:   seg = 7'h7E;
      5'h12:   seg = 7'h18;
      5'h13:   seg = 7'h24;
      5'h14:   seg = 7'h42;
      5'h15:   seg = 7'h31;
      5'h16:   seg = 7'h7F;
      5'h17:   seg = 7'h41;
      5'h18:   seg = 7'h6A;
      5'h19:   seg = 7'h71;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [SLOT_W-1:0]  r_slot_cnt;
  logic [DIG_W-1:0]   r_digit_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic               r_pending;
  logic [4:0]         r_stage_glyph [NUM_DIGITS];
  logic [4:0]         r_act_glyph   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_stage_dp;
  logic [NUM_DIGITS-1:0] r_act_dp;

  logic [4:0]            w_in_glyph [NUM_DIGITS];
  logic                  w_slot_end;
  logic                  w_frame_wrap;
  logic                  w_past_blank;
  logic [NUM_DIGITS-1:0] w_an_n;
  logic [6:0]            w_seg_n;
  logic                  w_dp_n;

  // Unpack the flat glyph bus into per-digit codes
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_in_glyph[i] = digits_in[5*i +: 5];
    end
  end

  assign w_slot_end   = enable && (r_slot_cnt == SLOT_LAST);
  assign w_frame_wrap = w_slot_end && (r_digit_idx == DIG_LAST);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_past_blank = 1'b1;
    end else begin : g_blank
      assign w_past_blank = (r_slot_cnt >= BLANK_L);
    end
  endgenerate

  // Slot and digit scan counters, parked at digit 0 slot 0 while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (!enable) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_slot_end) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= (r_digit_idx == DIG_LAST) ? '0 : r_digit_idx + 1'b1;
    end else begin
      r_slot_cnt  <= r_slot_cnt + 1'b1;
    end
  end

  // Free-running blink timebase, independent of enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  // Staging/active double buffer; disabled display has no frames so commits at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_stage_glyph[i] <= GLYPH_BLANK;
        r_act_glyph[i]   <= GLYPH_BLANK;
      end
      r_stage_dp <= '0;
      r_act_dp   <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (load) begin
        r_stage_glyph <= w_in_glyph;
        r_stage_dp    <= dp_in;
      end
      if (!enable || w_frame_wrap) begin
        if (load) begin
          r_act_glyph <= w_in_glyph;
          r_act_dp    <= dp_in;
        end else if (r_pending) begin
          r_act_glyph <= r_stage_glyph;
          r_act_dp    <= r_stage_dp;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Next-cycle display values from the current scan state
  always_comb begin
    w_an_n  = '1;
    w_seg_n = 7'h7F;
    w_dp_n  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (enable && w_past_blank && (r_digit_idx == DIG_W'(i)) &&
          !(blink_en[i] && r_blink_phase)) begin
        w_an_n[i] = 1'b0;
      end else begin
        w_an_n[i] = 1'b1;
      end
    end
    if (enable) begin
      w_seg_n = decode_glyph(r_act_glyph[r_digit_idx]);
      w_dp_n  = ~r_act_dp[r_digit_idx];
    end else begin
      w_seg_n = 7'h7F;
      w_dp_n  = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= w_seg_n;
      dp_n       <= w_dp_n;
      an_n       <= w_an_n;
      frame_done <= w_frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and scenario-driven bench for seg_scan_driver against a
// frame-position reference model (digit/slot/blink derived arithmetically).
module tb_seg_scan_driver;
  localparam int N  = 4;
  localparam int R  = 8;
  localparam int BK = 2;
  localparam int BL = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5*N-1:0] digits_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  blink_en = '0;
  logic          load = 1'b0;
  logic          enable = 1'b0;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [N-1:0]  an_n;
  logic          frame_done;

  seg_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(BK), .BLINK_DIV(BL)
  ) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blink_en(blink_en), .load(load), .enable(enable), .seg_n(seg_n),
    .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: scan position within a frame, time since reset
  logic [6:0] seg_tab [32];
  int         m_scan;
  int         m_t;
  logic [4:0] m_act [N];
  logic [4:0] m_stg [N];
  logic [N-1:0] m_adp, m_sdp;
  bit         m_pend;

  task automatic model_reset();
    m_scan = 0;
    m_t    = 0;
    for (int i = 0; i < N; i++) begin
      m_act[i] = 5'h16;
      m_stg[i] = 5'h16;
    end
    m_adp  = '0;
    m_sdp  = '0;
    m_pend = 1'b0;
  endtask

  // One clock: predict from pre-edge state and inputs, advance model, compare after edge
  task automatic tick();
    int digit, slot, phase;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    logic [N-1:0] e_an;
    logic [4:0] in_g [N];
    digit = m_scan / R;
    slot  = m_scan % R;
    phase = (m_t / BL) % 2;
    e_an  = '1;
    if (enable && slot >= BK && !(blink_en[digit] && phase == 1)) e_an[digit] = 1'b0;
    e_seg = enable ? seg_tab[m_act[digit]] : 7'h7F;
    e_dp  = enable ? ~m_adp[digit] : 1'b1;
    e_fd  = enable && (m_scan == N*R - 1);
    for (int i = 0; i < N; i++) in_g[i] = digits_in[5*i +: 5];
    if (load) begin
      m_stg = in_g;
      m_sdp = dp_in;
    end
    if (!enable || e_fd) begin
      if (load) begin
        m_act = in_g;
        m_adp = dp_in;
      end else if (m_pend) begin
        m_act = m_stg;
        m_adp = m_sdp;
      end
      m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    m_scan = enable ? (m_scan + 1) % (N*R) : 0;
    m_t    = (m_t + 1) % (2*BL);
    @(posedge clk);
    #1;
    check("seg_n", seg_n, e_seg);
    check("dp_n", dp_n, e_dp);
    check("an_n", an_n, e_an);
    check("frame_done", frame_done, e_fd);
    check("an_onehot", ($countones(~an_n) <= 1), 1);
    @(negedge clk);
  endtask

  task automatic load_once(input logic [5*N-1:0] d, input logic [N-1:0] dp);
    digits_in = d;
    dp_in     = dp;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  // Async assertion between edges; outputs must clear before any clock edge
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_seg_n", seg_n, 7'h7F);
    check("rst_dp_n", dp_n, 1'b1);
    check("rst_an_n", an_n, 4'hF);
    check("rst_frame_done", frame_done, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_scan(input int pos);
    int budget;
    budget = 0;
    while (!(enable && m_scan == pos) && budget < 100) begin
      tick();
      budget++;
    end
    check("scan_reach", budget < 100, 1);
  endtask

  initial begin
    seg_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38,
                7'h70, 7'h7E, 7'h18, 7'h24, 7'h42, 7'h31, 7'h7F, 7'h41,
                7'h6A, 7'h71, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("init_seg_n", seg_n, 7'h7F);
    check("init_an_n", an_n, 4'hF);
    check("init_dp_n", dp_n, 1'b1);
    check("init_frame_done", frame_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    enable = 1'b1;
    load_once({5'h12, 5'h13, 5'h05, 5'h03}, 4'b0010);
    repeat (100) tick();

    do_reset();
    repeat (10) tick();

    for (int c = 0; c < 32; c++) begin
      logic [4:0] code;
      code = 5'(c);
      load_once({5'h16, 5'h16, 5'h16, code}, 4'b0001);
      repeat (48) tick();
    end

    load_once({4{5'h01}}, 4'b0000);
    repeat (5) tick();
    load_once({4{5'h0A}}, 4'b1111);
    repeat (40) tick();
    wait_scan(N*R - 1);
    load_once({5'h07, 5'h06, 5'h04, 5'h02}, 4'b0100);
    repeat (10) tick();

    blink_en = 4'b0100;
    repeat (300) tick();
    blink_en = 4'b0000;

    wait_scan(2*R + 3);
    enable = 1'b0;
    repeat (2) tick();
    load_once({5'h05, 5'h05, 5'h05, 5'h09}, 4'b1001);
    repeat (3) tick();
    enable = 1'b1;
    repeat (20) tick();

    for (int k = 0; k < 2000; k++) begin
      enable    = ($urandom_range(0, 19) != 0);
      load      = ($urandom_range(0, 9) == 0);
      digits_in = 20'($urandom);
      dp_in     = 4'($urandom);
      blink_en  = 4'($urandom);
      tick();
      if (k == 1000) do_reset();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
